// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared encodings for the pipeline stall/flush sequencer: FSM state codes,
//   next-PC select codes, jump / branch / Mem_Write_Read encodings, the
//   5-bit register-index type and the control-bundle struct driven onto the
//   pipeline registers.
package pipe_ctrl_pkg;

    // Sequencer state
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_HALT     = 2'd2;

    // Next-PC source
    localparam logic [1:0] PC_SEQ = 2'b00;  // PC+4
    localparam logic [1:0] PC_BR  = 2'b01;  // branch address
    localparam logic [1:0] PC_JMP = 2'b10;  // jump target
    localparam logic [1:0] PC_JR  = 2'b11;  // jump register

    // Jump codes from EX/MEM (11 is treated as none)
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    // Branch codes from EX/MEM (11 is treated as none)
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    // Mem_Write_Read: anything other than idle is an access
    localparam logic [1:0] MWR_IDLE = 2'b00;

    typedef logic [4:0] reg_idx_t;

    // Control bundle for the pipeline registers
    typedef struct packed {
        logic       pc_we;
        logic       if_id_we;
        logic       id_ex_we;
        logic       ex_mem_we;
        logic       if_id_flush;
        logic       id_ex_flush;
        logic       ex_mem_flush;
        logic       mem_wb_flush;
        logic [1:0] pc_sel;
    } ctrl_t;

    // Normal flow: everything advances, no bubbles
    localparam ctrl_t CTRL_DEFAULT = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                       ex_mem_we: 1'b1, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
                                       mem_wb_flush: 1'b0, pc_sel: PC_SEQ};

    // Memory wait: hold everything up to EX/MEM, push a bubble into MEM/WB
    localparam ctrl_t CTRL_FREEZE  = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                       ex_mem_we: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
                                       mem_wb_flush: 1'b1, pc_sel: PC_SEQ};

    // Debug halt: hold everything, no bubbles
    localparam ctrl_t CTRL_HALT    = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                       ex_mem_we: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
                                       mem_wb_flush: 1'b0, pc_sel: PC_SEQ};

    // Held in reset: nothing written, every stage loads a bubble
    localparam ctrl_t CTRL_RESET   = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                       ex_mem_we: 1'b0, if_id_flush: 1'b1,
                                       id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
                                       mem_wb_flush: 1'b1, pc_sel: PC_SEQ};

    // Redirect target select for a taken control transfer; jumps outrank branches
    function automatic logic [1:0] redirect_sel(input logic [1:0] jump);
        if (jump == JMP_J)       return PC_JMP;
        else if (jump == JMP_JR) return PC_JR;
        else                     return PC_BR;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports: clk, rst_n (async low), clear (sync, wins over inc), inc, count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the five-stage pipeline.
//   Inputs : ID source regs + use flags, EX load/dest info, EX/MEM jump/branch/
//            zero-flag and Mem_Write_Read, data-memory ready, debug halt_req.
//   Outputs: PC / IF-ID / ID-EX / EX-MEM write enables, four stage flushes,
//            pc_sel, registered halt_ack, sticky mem_err, and saturating
//            stall_cycles / redirect_count.
//   Control outputs are combinational from state and inputs; while rst_n is
//   low they are forced to the reset bundle without waiting for a clock.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  reg_idx_t         id_rs,
    input  reg_idx_t         id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic             ex_regwrite,
    input  reg_idx_t         ex_dest,
    input  logic [1:0]       mem_jump,
    input  logic [1:0]       mem_branch_inst,
    input  logic             mem_zf,
    input  logic [1:0]       mem_wr_rd,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       pc_sel,
    output logic             halt_ack,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t     state, state_n;
    logic [7:0] wait_cnt, wait_cnt_n;
    logic       mem_busy, taken, lu;
    logic       err_set, redir_inc;
    ctrl_t      ctrl, ctrl_o;

    // Hazard detection
    always_comb begin
        mem_busy = (mem_wr_rd != MWR_IDLE) && !mem_ready;
        taken    = (mem_jump == JMP_J) || (mem_jump == JMP_JR) ||
                   ((mem_branch_inst == BR_BEQ) &&  mem_zf) ||
                   ((mem_branch_inst == BR_BNE) && !mem_zf);
        lu       = ex_mem_read && ex_regwrite && (ex_dest != '0) &&
                   ((id_uses_rs && (id_rs == ex_dest)) ||
                    (id_uses_rt && (id_rt == ex_dest)));
    end

    // Sequencer
    always_comb begin
        logic run_rules;
        ctrl       = CTRL_DEFAULT;
        state_n    = state;
        wait_cnt_n = wait_cnt;
        err_set    = 1'b0;
        redir_inc  = 1'b0;
        run_rules  = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    ctrl       = CTRL_FREEZE;
                    state_n    = ST_MEM_WAIT;
                    wait_cnt_n = 8'd1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_busy) begin
                    run_rules = 1'b1;
                    state_n   = ST_RUN;
                end else if (wait_cnt >= TMO) begin
                    // Give up on the access: flag it and let the pipe move on
                    run_rules = 1'b1;
                    err_set   = 1'b1;
                    state_n   = ST_RUN;
                end else begin
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            ST_HALT: begin
                ctrl    = CTRL_HALT;
                state_n = halt_req ? ST_HALT : ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase

        // Release cycles out of MEM_WAIT see the same taken/load-use rules;
        // EX/MEM was held, so a redirect pending there is applied now.
        if (run_rules) begin
            if (taken) begin
                ctrl.pc_sel       = redirect_sel(mem_jump);
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
                redir_inc         = 1'b1;
            end else if (lu) begin
                ctrl.pc_we       = 1'b0;
                ctrl.if_id_we    = 1'b0;
                ctrl.id_ex_flush = 1'b1;
            end else if (halt_req && (state == ST_RUN)) begin
                state_n = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            halt_ack <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            halt_ack <= (state_n == ST_HALT);
            if (err_set)
                mem_err <= 1'b1;
        end
    end

    assign ctrl_o       = rst_n ? ctrl : CTRL_RESET;
    assign pc_we        = ctrl_o.pc_we;
    assign if_id_we     = ctrl_o.if_id_we;
    assign id_ex_we     = ctrl_o.id_ex_we;
    assign ex_mem_we    = ctrl_o.ex_mem_we;
    assign if_id_flush  = ctrl_o.if_id_flush;
    assign id_ex_flush  = ctrl_o.id_ex_flush;
    assign ex_mem_flush = ctrl_o.ex_mem_flush;
    assign mem_wb_flush = ctrl_o.mem_wb_flush;
    assign pc_sel       = ctrl_o.pc_sel;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (!ctrl.pc_we),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (redir_inc),
        .count (redirect_count)
    );

endmodule
